// File: rtl/br_pkg.sv
// Shared constants and enums for the BR register-file write-port controller.
package br_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; rr points at the requester favoured on a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  br_pkg::req_e rr_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_q == br_pkg::REQ_A) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // After a grant the other requester becomes favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= br_pkg::REQ_A;
    end else if (advance) begin
      rr_q <= gnt[0] ? br_pkg::REQ_B : br_pkg::REQ_A;
    end
  end

endmodule

// File: rtl/br_wb_arbiter.sv
// Shares BR's single write port between ALU (A) and load (B) writeback,
// preceded by a zero sweep of every register after reset or clear.
module br_wb_arbiter #(
  parameter int unsigned NREG = br_pkg::NREG,
  parameter int unsigned AW   = br_pkg::AW,
  parameter int unsigned DW   = br_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          a_valid,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic [AW-1:0] Writereg,
  output logic [DW-1:0] WriteData,
  output logic          Regwrite,
  output logic          init_done
);

  br_pkg::state_e state_q, state_d;
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           sweep_end_q, sweep_end_d;
  logic [AW-1:0]  wreg_q, wreg_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           wen_q, wen_d;
  logic           run_open;
  logic [1:0]     gnt;

  // Requests are only visible to the arbiter while running and not clearing.
  assign run_open = (state_q == br_pkg::S_RUN) && !clr;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     ({b_valid && run_open, a_valid && run_open}),
    .advance (|gnt),
    .gnt     (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sweep_end_d = sweep_end_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    case (state_q)
      br_pkg::S_INIT: begin
        if (sweep_end_q) begin
          // Last sweep write is on the bus; open for requests next cycle.
          state_d     = br_pkg::S_RUN;
          sweep_end_d = 1'b0;
          cnt_d       = '0;
        end else begin
          wen_d   = 1'b1;
          wreg_d  = cnt_q;
          wdata_d = '0;
          if (cnt_q == AW'(NREG - 1)) begin
            sweep_end_d = 1'b1;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      br_pkg::S_RUN: begin
        if (clr) begin
          state_d     = br_pkg::S_INIT;
          cnt_d       = '0;
          sweep_end_d = 1'b0;
        end else if (gnt[0]) begin
          wreg_d  = a_reg;
          wdata_d = a_data;
          wen_d   = (a_reg != '0);
        end else if (gnt[1]) begin
          wreg_d  = b_reg;
          wdata_d = b_data;
          wen_d   = (b_reg != '0);
        end
      end
      default: begin
        state_d = br_pkg::S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= br_pkg::S_INIT;
      cnt_q       <= '0;
      sweep_end_q <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sweep_end_q <= sweep_end_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
    end
  end

  assign Writereg  = wreg_q;
  assign WriteData = wdata_q;
  assign Regwrite  = wen_q;
  assign init_done = (state_q == br_pkg::S_RUN);

endmodule
